// File: rtl/svc_axi_axil_reflect_wr.sv
// AXI4 write -> AXI-lite write reflector: each W beat becomes one AXI-lite write; one merged B is returned.
// Optional SVC_AXI_AXIL_REFLECT_WR_BURST_EN splits bursts; without it multi-beat bursts are drained and answered SLVERR.
module svc_axi_axil_reflect_wr #(
  parameter int unsigned AXI_ADDR_WIDTH = 20,
  parameter int unsigned AXI_DATA_WIDTH = 16,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic [AXI_USER_WIDTH-1:0]     s_axi_awuser,

  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wlast,

  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic [AXI_USER_WIDTH-1:0]     s_axi_buser,

  output logic                          m_axil_awvalid,
  input  logic                          m_axil_awready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
  output logic                          m_axil_wvalid,
  input  logic                          m_axil_wready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
  input  logic                          m_axil_bvalid,
  output logic                          m_axil_bready,
  input  logic [1:0]                    m_axil_bresp
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_LITE   = 3'd2,
    S_WAIT_B = 3'd3,
    S_RESP   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [7:0]                  len_q, len_d;
  logic [2:0]                  size_q, size_d;
  logic [1:0]                  burst_q, burst_d;
  logic [7:0]                  count_q, count_d;

  logic                        awready_d, wready_d, bvalid_d, bready_d;
  logic [AXI_ID_WIDTH-1:0]     bid_d;
  logic [AXI_USER_WIDTH-1:0]   buser_d;
  logic [1:0]                  acc_d;
  logic                        m_awvalid_d, m_wvalid_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_d;
  logic [STRB_WIDTH-1:0]       wstrb_d;

  logic                        aw_hs, w_hs, mb_hs, b_hs;
  logic                        aw_done, w_done, last_beat;
  logic                        split_ok;
  logic [AXI_ADDR_WIDTH-1:0]   addr_step;
  logic [1:0]                  merged_resp;

  // Beat count comes from awlen, so wlast carries no extra information.
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

`ifdef SVC_AXI_AXIL_REFLECT_WR_BURST_EN
  assign split_ok = 1'b1;
`else
  assign split_ok = (s_axi_awlen == 8'd0);
`endif

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_hs      = s_axi_wvalid & s_axi_wready;
  assign mb_hs     = m_axil_bvalid & m_axil_bready;
  assign b_hs      = s_axi_bvalid & s_axi_bready;
  assign aw_done   = ~m_axil_awvalid | m_axil_awready;
  assign w_done    = ~m_axil_wvalid | m_axil_wready;
  assign last_beat = (count_q == len_q);
  // WRAP is deliberately advanced like INCR.
  assign addr_step   = AXI_ADDR_WIDTH'(1) << size_q;
  assign merged_resp = (m_axil_bresp > s_axi_bresp) ? m_axil_bresp : s_axi_bresp;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (aw_hs) state_d = split_ok ? S_DATA : S_DRAIN;
      S_DATA:   if (w_hs) state_d = S_LITE;
      S_LITE:   if (aw_done && w_done) state_d = S_WAIT_B;
      S_WAIT_B: if (mb_hs) state_d = last_beat ? S_RESP : S_DATA;
      S_DRAIN:  if (w_hs && last_beat) state_d = S_RESP;
      S_RESP:   if (b_hs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of registered outputs and transaction context
  always_comb begin
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    count_d     = count_q;
    bid_d       = s_axi_bid;
    buser_d     = s_axi_buser;
    acc_d       = s_axi_bresp;
    addr_d      = m_axil_awaddr;
    wdata_d     = m_axil_wdata;
    wstrb_d     = m_axil_wstrb;
    m_awvalid_d = m_axil_awvalid;
    m_wvalid_d  = m_axil_wvalid;

    awready_d = (state_d == S_IDLE);
    wready_d  = (state_d == S_DATA) || (state_d == S_DRAIN);
    bready_d  = (state_d == S_WAIT_B);
    bvalid_d  = (state_d == S_RESP);

    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          bid_d   = s_axi_awid;
          buser_d = s_axi_awuser;
          addr_d  = s_axi_awaddr;
          len_d   = s_axi_awlen;
          size_d  = s_axi_awsize;
          burst_d = s_axi_awburst;
          count_d = 8'd0;
          acc_d   = split_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          wdata_d     = s_axi_wdata;
          wstrb_d     = s_axi_wstrb;
          m_awvalid_d = 1'b1;
          m_wvalid_d  = 1'b1;
        end
      end
      S_LITE: begin
        if (m_axil_awvalid && m_axil_awready) m_awvalid_d = 1'b0;
        if (m_axil_wvalid && m_axil_wready)   m_wvalid_d  = 1'b0;
      end
      S_WAIT_B: begin
        if (mb_hs) begin
          acc_d = merged_resp;
          if (!last_beat) begin
            count_d = count_q + 8'd1;
            if (burst_q != BURST_FIXED) addr_d = m_axil_awaddr + addr_step;
          end
        end
      end
      S_DRAIN: begin
        if (w_hs && !last_beat) count_d = count_q + 8'd1;
      end
      default: ;
    endcase
  end

  // Output and context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q          <= '0;
      size_q         <= '0;
      burst_q        <= '0;
      count_q        <= '0;
      s_axi_awready  <= 1'b0;
      s_axi_wready   <= 1'b0;
      s_axi_bvalid   <= 1'b0;
      s_axi_bid      <= '0;
      s_axi_buser    <= '0;
      s_axi_bresp    <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_awaddr  <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_bready  <= 1'b0;
    end else begin
      len_q          <= len_d;
      size_q         <= size_d;
      burst_q        <= burst_d;
      count_q        <= count_d;
      s_axi_awready  <= awready_d;
      s_axi_wready   <= wready_d;
      s_axi_bvalid   <= bvalid_d;
      s_axi_bid      <= bid_d;
      s_axi_buser    <= buser_d;
      s_axi_bresp    <= acc_d;
      m_axil_awvalid <= m_awvalid_d;
      m_axil_awaddr  <= addr_d;
      m_axil_wvalid  <= m_wvalid_d;
      m_axil_wdata   <= wdata_d;
      m_axil_wstrb   <= wstrb_d;
      m_axil_bready  <= bready_d;
    end
  end

endmodule
